// File: rtl/div_ctrl.sv
// Request/response sequencer for the iterative unsigned divider: sign handling, special cases, flush.
// Optional `DIV_RESULT_CACHE_EN: reuse the last divider result for a matching a/b/signedness request.
module div_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld_i,
  output logic             req_rdy_o,
  input  logic [1:0]       req_op_i,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             resp_vld_o,
  input  logic             resp_rdy_i,
  output logic [31:0]      resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             busy_o,
  output logic [31:0]      div_div1_o,
  output logic [31:0]      div_div2_o,
  output logic             div_vld_o,
  input  logic [31:0]      div_q_i,
  input  logic [31:0]      div_r_i,
  input  logic             div_rdy_i
);

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_ISSUE = 5'b00010;
  localparam logic [4:0] S_WAIT  = 5'b00100;
  localparam logic [4:0] S_RESP  = 5'b01000;
  localparam logic [4:0] S_DRAIN = 5'b10000;

  logic [4:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [31:0]      div1_q, div1_d;
  logic [31:0]      div2_q, div2_d;
  logic             dvld_q, dvld_d;
  logic             rvld_q, rvld_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;

  logic        is_signed, a_neg, b_neg, b_zero, ovf, accept;
  logic [31:0] a_mag, b_mag, special_dat, q_fix, r_fix, div_res;
  logic        hit;
  logic [31:0] hit_dat;

  assign is_signed   = ~req_op_i[0];
  assign a_neg       = is_signed & req_a_i[31];
  assign b_neg       = is_signed & req_b_i[31];
  assign a_mag       = a_neg ? (~req_a_i + 32'd1) : req_a_i;
  assign b_mag       = b_neg ? (~req_b_i + 32'd1) : req_b_i;
  assign b_zero      = (req_b_i == 32'd0);
  assign ovf         = is_signed & (req_a_i == 32'h8000_0000) & (req_b_i == 32'hFFFF_FFFF);
  assign special_dat = b_zero ? (req_op_i[1] ? req_a_i : 32'hFFFF_FFFF)
                              : (req_op_i[1] ? 32'd0   : 32'h8000_0000);

  assign req_rdy_o = state_q[0] & ~flush_i;
  assign accept    = req_vld_i & req_rdy_o;

  assign q_fix   = qneg_q ? (~div_q_i + 32'd1) : div_q_i;
  assign r_fix   = rneg_q ? (~div_r_i + 32'd1) : div_r_i;
  assign div_res = op_q[1] ? r_fix : q_fix;

`ifdef DIV_RESULT_CACHE_EN
  logic [31:0] last_a_q, last_b_q, last_q_q, last_r_q, pend_a_q, pend_b_q;
  logic        last_s_q, pend_s_q, cvld_q;

  assign hit     = cvld_q & (req_a_i == last_a_q) & (req_b_i == last_b_q) & (is_signed == last_s_q);
  assign hit_dat = req_op_i[1] ? last_r_q : last_q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_a_q <= '0;
      last_b_q <= '0;
      last_q_q <= '0;
      last_r_q <= '0;
      last_s_q <= 1'b0;
      pend_a_q <= '0;
      pend_b_q <= '0;
      pend_s_q <= 1'b0;
      cvld_q   <= 1'b0;
    end else begin
      if (accept) begin
        pend_a_q <= req_a_i;
        pend_b_q <= req_b_i;
        pend_s_q <= is_signed;
      end
      // Any flush while the divider is involved invalidates the cache.
      if (flush_i && (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_DRAIN)) begin
        cvld_q <= 1'b0;
      end else if (state_q == S_WAIT && div_rdy_i) begin
        last_a_q <= pend_a_q;
        last_b_q <= pend_b_q;
        last_s_q <= pend_s_q;
        last_q_q <= q_fix;
        last_r_q <= r_fix;
        cvld_q   <= 1'b1;
      end
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_dat = 32'd0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div1_d  = div1_q;
    div2_d  = div2_q;
    rdata_d = rdata_q;
    rtag_d  = rtag_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = req_op_i;
          qneg_d = is_signed & (req_a_i[31] ^ req_b_i[31]);
          rneg_d = a_neg;
          rtag_d = req_tag_i;
          // A zero divisor must never reach the divider, which samples div2 continuously.
          if (!b_zero) begin
            div1_d = a_mag;
            div2_d = b_mag;
          end
          if (b_zero || ovf) begin
            rdata_d = special_dat;
            state_d = S_RESP;
          end else if (hit) begin
            rdata_d = hit_dat;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = flush_i ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (div_rdy_i) begin
          if (flush_i) begin
            state_d = S_IDLE;
          end else begin
            rdata_d = div_res;
            state_d = S_RESP;
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_RESP:  if (flush_i || resp_rdy_i) state_d = S_IDLE;
      S_DRAIN: if (div_rdy_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    dvld_d = (state_d == S_ISSUE);
    rvld_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div1_q  <= '0;
      div2_q  <= '0;
      dvld_q  <= 1'b0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
      rtag_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      div1_q  <= div1_d;
      div2_q  <= div2_d;
      dvld_q  <= dvld_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
      rtag_q  <= rtag_d;
    end
  end

  assign busy_o      = ~state_q[0];
  assign div_div1_o  = div1_q;
  assign div_div2_o  = div2_q;
  assign div_vld_o   = dvld_q;
  assign resp_vld_o  = rvld_q;
  assign resp_data_o = rdata_q;
  assign resp_tag_o  = rtag_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a 3-cycle behavioural divider attached to the divider port.
module tb_div_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld_i = 1'b0;
  logic        req_rdy_o;
  logic [1:0]  req_op_i = 2'd0;
  logic [31:0] req_a_i = '0;
  logic [31:0] req_b_i = '0;
  logic [4:0]  req_tag_i = '0;
  logic        flush_i = 1'b0;
  logic        resp_vld_o;
  logic        resp_rdy_i = 1'b0;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_tag_o;
  logic        busy_o;
  logic [31:0] div_div1_o, div_div2_o;
  logic        div_vld_o;
  logic [31:0] div_q_i, div_r_i;
  logic        div_rdy_i;

  int n_chk = 0;
  int n_fail = 0;
  int starts = 0;
  int zero_div_starts = 0;
  int dcnt;
  logic dbusy;

`ifdef DIV_RESULT_CACHE_EN
  localparam int REM_LAT = 1;
  localparam int REM_STARTS = 0;
`else
  localparam int REM_LAT = 5;
  localparam int REM_STARTS = 1;
`endif

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_ctrl #(.TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
    .flush_i(flush_i),
    .resp_vld_o(resp_vld_o), .resp_rdy_i(resp_rdy_i), .resp_data_o(resp_data_o),
    .resp_tag_o(resp_tag_o), .busy_o(busy_o),
    .div_div1_o(div_div1_o), .div_div2_o(div_div2_o), .div_vld_o(div_vld_o),
    .div_q_i(div_q_i), .div_r_i(div_r_i), .div_rdy_i(div_rdy_i)
  );

  always #5 clk = ~clk;

  // Divider stand-in: done strobe three cycles after the start pulse (shift count 0).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dbusy     <= 1'b0;
      dcnt      <= 0;
      div_rdy_i <= 1'b0;
      div_q_i   <= '0;
      div_r_i   <= '0;
    end else begin
      div_rdy_i <= 1'b0;
      if (div_vld_o) begin
        starts <= starts + 1;
        if (div_div2_o == 32'd0) zero_div_starts <= zero_div_starts + 1;
      end
      if (div_vld_o && !dbusy) begin
        dbusy   <= 1'b1;
        dcnt    <= 1;
        div_q_i <= (div_div2_o == 0) ? 32'hFFFF_FFFF : div_div1_o / div_div2_o;
        div_r_i <= (div_div2_o == 0) ? div_div1_o : div_div1_o % div_div2_o;
      end else if (dbusy) begin
        if (dcnt == 0) begin
          div_rdy_i <= 1'b1;
          dbusy     <= 1'b0;
        end else begin
          dcnt <= dcnt - 1;
        end
      end
    end
  end

  // All tasks start and end just after a falling edge.
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
    req_vld_i = 1'b1; req_op_i = op; req_a_i = a; req_b_i = b; req_tag_i = tag;
    @(negedge clk);
    req_vld_i = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_vld_o && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_vld_o) lat = 999;
  endtask

  task automatic finish_resp();
    resp_rdy_i = 1'b1;
    @(negedge clk);
    resp_rdy_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++; if (resp_vld_o !== 1'b0) begin n_fail++; $display("FAIL rst_resp_vld got %b exp 0", resp_vld_o); end
    n_chk++; if (resp_data_o !== 32'd0) begin n_fail++; $display("FAIL rst_resp_data got %h exp 0", resp_data_o); end
    n_chk++; if (resp_tag_o !== 5'd0) begin n_fail++; $display("FAIL rst_resp_tag got %h exp 0", resp_tag_o); end
    n_chk++; if (div_vld_o !== 1'b0) begin n_fail++; $display("FAIL rst_div_vld got %b exp 0", div_vld_o); end
    n_chk++; if ({div_div1_o, div_div2_o} !== 64'd0) begin n_fail++; $display("FAIL rst_div_ops got %h/%h exp 0/0", div_div1_o, div_div2_o); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy_o); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (req_rdy_o !== 1'b1) begin n_fail++; $display("FAIL rst_req_rdy got %b exp 1", req_rdy_o); end
  endtask

  task automatic test_div_signed();
    int lat, s0;
    s0 = starts;
    do_req(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5);
    n_chk++; if (div_vld_o !== 1'b1) begin n_fail++; $display("FAIL div_start got %b exp 1", div_vld_o); end
    n_chk++; if (div_div1_o !== 32'd7) begin n_fail++; $display("FAIL div_div1 got %h exp 7", div_div1_o); end
    n_chk++; if (div_div2_o !== 32'd2) begin n_fail++; $display("FAIL div_div2 got %h exp 2", div_div2_o); end
    wait_resp(lat);
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL div_lat got %0d exp 5", lat); end
    n_chk++; if (resp_data_o !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_data got %h exp fffffffd", resp_data_o); end
    n_chk++; if (resp_tag_o !== 5'd5) begin n_fail++; $display("FAIL div_tag got %h exp 5", resp_tag_o); end
    finish_resp();
    do_req(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6);
    wait_resp(lat);
    n_chk++; if (lat !== REM_LAT) begin n_fail++; $display("FAIL rem_lat got %0d exp %0d", lat, REM_LAT); end
    n_chk++; if (resp_data_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_data got %h exp ffffffff", resp_data_o); end
    n_chk++; if (resp_tag_o !== 5'd6) begin n_fail++; $display("FAIL rem_tag got %h exp 6", resp_tag_o); end
    n_chk++; if (starts - s0 !== 1 + REM_STARTS) begin n_fail++; $display("FAIL div_rem_starts got %0d exp %0d", starts - s0, 1 + REM_STARTS); end
    finish_resp();
  endtask

  task automatic test_div_by_zero();
    int s0;
    s0 = starts;
    do_req(OP_DIVU, 32'd100, 32'd0, 5'd1);
    n_chk++; if (resp_vld_o !== 1'b1) begin n_fail++; $display("FAIL dz_lat resp_vld got %b exp 1", resp_vld_o); end
    n_chk++; if (div_vld_o !== 1'b0) begin n_fail++; $display("FAIL dz_no_start got %b exp 0", div_vld_o); end
    n_chk++; if (resp_data_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_divu got %h exp ffffffff", resp_data_o); end
    finish_resp();
    do_req(OP_REMU, 32'd100, 32'd0, 5'd2);
    n_chk++; if (resp_vld_o !== 1'b1) begin n_fail++; $display("FAIL dz_rem_vld got %b exp 1", resp_vld_o); end
    n_chk++; if (resp_data_o !== 32'd100) begin n_fail++; $display("FAIL dz_remu got %h exp 64", resp_data_o); end
    finish_resp();
    do_req(OP_DIV, 32'hFFFF_FFF0, 32'd0, 5'd3);
    n_chk++; if (resp_data_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_div_signed got %h exp ffffffff", resp_data_o); end
    finish_resp();
    n_chk++; if (starts !== s0) begin n_fail++; $display("FAIL dz_starts got %0d exp %0d", starts, s0); end
  endtask

  task automatic test_overflow();
    int s0;
    s0 = starts;
    do_req(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
    n_chk++; if (resp_vld_o !== 1'b1) begin n_fail++; $display("FAIL ovf_lat resp_vld got %b exp 1", resp_vld_o); end
    n_chk++; if (resp_data_o !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_div got %h exp 80000000", resp_data_o); end
    finish_resp();
    do_req(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    n_chk++; if (resp_data_o !== 32'd0) begin n_fail++; $display("FAIL ovf_rem got %h exp 0", resp_data_o); end
    finish_resp();
    n_chk++; if (starts !== s0) begin n_fail++; $display("FAIL ovf_starts got %0d exp %0d", starts, s0); end
  endtask

  task automatic test_backpressure();
    int lat;
    do_req(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd9);
    wait_resp(lat);
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL bp_lat got %0d exp 5", lat); end
    // A competing request is offered throughout; it must not be taken.
    req_vld_i = 1'b1; req_op_i = OP_DIVU; req_a_i = 32'd5; req_b_i = 32'd0; req_tag_i = 5'd3;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (resp_vld_o !== 1'b1) begin n_fail++; $display("FAIL bp_vld[%0d] got %b exp 1", i, resp_vld_o); end
      n_chk++; if (resp_data_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL bp_data[%0d] got %h exp ffffffff", i, resp_data_o); end
      n_chk++; if (resp_tag_o !== 5'd9) begin n_fail++; $display("FAIL bp_tag[%0d] got %h exp 9", i, resp_tag_o); end
      n_chk++; if (req_rdy_o !== 1'b0) begin n_fail++; $display("FAIL bp_req_rdy[%0d] got %b exp 0", i, req_rdy_o); end
      @(negedge clk);
    end
    resp_rdy_i = 1'b1;
    @(negedge clk);
    resp_rdy_i = 1'b0;
    req_vld_i  = 1'b0;
    n_chk++; if (resp_vld_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_b2b resp_vld got %b exp 0", resp_vld_o); end
    n_chk++; if (req_rdy_o !== 1'b1) begin n_fail++; $display("FAIL bp_idle req_rdy got %b exp 1", req_rdy_o); end
  endtask

  task automatic test_flush();
    int lat, s0;
    do_req(OP_DIVU, 32'd1000, 32'd3, 5'd4);
    n_chk++; if (div_vld_o !== 1'b1) begin n_fail++; $display("FAIL fl_start got %b exp 1", div_vld_o); end
    repeat (2) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    n_chk++; if (div_rdy_i !== 1'b1) begin n_fail++; $display("FAIL fl_env_done got %b exp 1", div_rdy_i); end
    n_chk++; if ({busy_o, req_rdy_o, resp_vld_o} !== 3'b100) begin n_fail++; $display("FAIL fl_drain busy/rdy/vld got %b exp 100", {busy_o, req_rdy_o, resp_vld_o}); end
    @(negedge clk);
    n_chk++; if ({busy_o, req_rdy_o, resp_vld_o} !== 3'b010) begin n_fail++; $display("FAIL fl_idle busy/rdy/vld got %b exp 010", {busy_o, req_rdy_o, resp_vld_o}); end
    do_req(OP_DIVU, 32'd9, 32'd3, 5'd10);
    wait_resp(lat);
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL fl_next_lat got %0d exp 5", lat); end
    n_chk++; if (resp_data_o !== 32'd3) begin n_fail++; $display("FAIL fl_next_data got %h exp 3", resp_data_o); end
    n_chk++; if (resp_tag_o !== 5'd10) begin n_fail++; $display("FAIL fl_next_tag got %h exp a", resp_tag_o); end
    // Flush while a response is pending drops it.
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    n_chk++; if ({resp_vld_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL fl_resp_drop vld/busy got %b exp 00", {resp_vld_o, busy_o}); end
    // Flush in IDLE blocks the accept.
    s0 = starts;
    flush_i = 1'b1; req_vld_i = 1'b1; req_op_i = OP_DIVU; req_a_i = 32'd8; req_b_i = 32'd0; req_tag_i = 5'd11;
    #1;
    n_chk++; if (req_rdy_o !== 1'b0) begin n_fail++; $display("FAIL fl_idle_rdy got %b exp 0", req_rdy_o); end
    @(negedge clk);
    flush_i = 1'b0; req_vld_i = 1'b0;
    n_chk++; if ({resp_vld_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL fl_idle_accept vld/busy got %b exp 00", {resp_vld_o, busy_o}); end
    n_chk++; if (starts !== s0) begin n_fail++; $display("FAIL fl_idle_starts got %0d exp %0d", starts, s0); end
  endtask

`ifdef DIV_RESULT_CACHE_EN
  task automatic test_cache();
    int lat, s0;
    do_req(OP_DIV, 32'd100, 32'd7, 5'd12);
    wait_resp(lat);
    n_chk++; if (resp_data_o !== 32'd14) begin n_fail++; $display("FAIL c_div got %h exp e", resp_data_o); end
    finish_resp();
    s0 = starts;
    do_req(OP_REM, 32'd100, 32'd7, 5'd13);
    wait_resp(lat);
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL c_hit_lat got %0d exp 1", lat); end
    n_chk++; if (resp_data_o !== 32'd2) begin n_fail++; $display("FAIL c_hit_data got %h exp 2", resp_data_o); end
    n_chk++; if (starts !== s0) begin n_fail++; $display("FAIL c_hit_starts got %0d exp %0d", starts, s0); end
    finish_resp();
    do_req(OP_DIVU, 32'd50, 32'd5, 5'd14);
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    repeat (3) @(negedge clk);
    s0 = starts;
    do_req(OP_REM, 32'd100, 32'd7, 5'd15);
    wait_resp(lat);
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL c_miss_lat got %0d exp 5", lat); end
    n_chk++; if (resp_data_o !== 32'd2) begin n_fail++; $display("FAIL c_miss_data got %h exp 2", resp_data_o); end
    n_chk++; if (starts !== s0 + 1) begin n_fail++; $display("FAIL c_miss_starts got %0d exp %0d", starts, s0 + 1); end
    finish_resp();
  endtask
`endif

  task automatic test_reset_midop();
    do_req(OP_DIVU, 32'd1000, 32'd3, 5'd16);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++; if ({busy_o, div_vld_o, resp_vld_o} !== 3'b000) begin n_fail++; $display("FAIL mr_clear busy/dvld/rvld got %b exp 000", {busy_o, div_vld_o, resp_vld_o}); end
    n_chk++; if (div_div1_o !== 32'd0) begin n_fail++; $display("FAIL mr_div1 got %h exp 0", div_div1_o); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_chk++; if (resp_vld_o !== 1'b0) begin n_fail++; $display("FAIL mr_no_resp[%0d] got %b exp 0", i, resp_vld_o); end
    end
    n_chk++; if (req_rdy_o !== 1'b1) begin n_fail++; $display("FAIL mr_req_rdy got %b exp 1", req_rdy_o); end
  endtask

  initial begin
    test_reset();
    test_div_signed();
    test_div_by_zero();
    test_overflow();
    test_backpressure();
    test_flush();
`ifdef DIV_RESULT_CACHE_EN
    test_cache();
`endif
    test_reset_midop();
    n_chk++; if (zero_div_starts !== 0) begin n_fail++; $display("FAIL zero_divisor_start got %0d exp 0", zero_div_starts); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller between the execute stage and the iterative 32-bit unsigned divider.
- Accepts RV32M DIV/DIVU/REM/REMU requests over a valid/ready handshake.
- Converts signed operands to magnitudes and handles divide-by-zero and signed overflow without using the divider.
- Issues a one-cycle start pulse to the divider, holds its operands stable, sign-corrects the result and returns it over a valid/ready response port.

Parameters:
- TAG_W, 5, width of the destination tag carried from request to response.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_vld_i  in  1  request valid
- req_rdy_o  out  1  request ready; high only in IDLE
- req_op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_a_i  in  32  dividend
- req_b_i  in  32  divisor
- req_tag_i  in  TAG_W  destination tag
- flush_i  in  1  discard the in-flight operation
- resp_vld_o  out  1  response valid
- resp_rdy_i  in  1  response accepted
- resp_data_o  out  32  quotient or remainder
- resp_tag_o  out  TAG_W  tag of the response
- busy_o  out  1  high whenever state is not IDLE
- div_div1_o  out  32  divider dividend (magnitude)
- div_div2_o  out  32  divider divisor (magnitude)
- div_vld_o  out  1  divider start pulse
- div_q_i  in  32  divider quotient
- div_r_i  in  32  divider remainder
- div_rdy_i  in  1  divider done strobe

Behaviour:
- Reset (asynchronous): state IDLE. All registered outputs reset to 0: resp_vld_o, resp_data_o, resp_tag_o, div_vld_o, div_div1_o, div_div2_o. busy_o is 0.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN (one-hot).
- IDLE:
  - req_rdy_o is 1. A request is accepted on the cycle req_vld_i and req_rdy_o are both high.
  - On accept, register op, tag, sign_q = signed & (a[31]^b[31]) and sign_r = signed & a[31].
  - Register div_div1_o = signed&a[31] ? -a : a, and div_div2_o = signed&b[31] ? -b : b.
  - Special cases go straight to RESP with the result latched:
    - b==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
    - Signed op with a==0x80000000 and b==0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
  - All other requests go to ISSUE.
- ISSUE: div_vld_o=1 for exactly this cycle, then WAIT. div_vld_o is never asserted in any other state, so the divider is never re-triggered from its done state.
- Operand hold: div_div1_o and div_div2_o stay stable from ISSUE until div_rdy_i is seen, because the divider reads div2 continuously. They never carry a zero divisor into the divider.
- WAIT: on div_rdy_i, capture the result and go to RESP.
  - DIV/DIVU: result = sign_q ? -div_q_i : div_q_i.
  - REM/REMU: result = sign_r ? -div_r_i : div_r_i.
- RESP: resp_vld_o=1 with data and tag held stable until resp_rdy_i. The handshake cycle returns to IDLE; no back-to-back accept in that same cycle.
- Latency:
  - Special case: resp_vld_o asserts 1 cycle after accept.
  - Normal, accept at cycle T: div_vld_o at T+1, the divider needs at least 3 cycles, div_rdy_i at T+4+k (k = shift count), resp_vld_o at T+5+k.
- flush_i:
  - In ISSUE or WAIT: go to DRAIN. If flush_i and div_rdy_i coincide in WAIT, go to IDLE.
  - In RESP: drop the response (resp_vld_o=0 next cycle) and go to IDLE.
  - In IDLE: suppresses the accept (req_rdy_o=0 that cycle).
  - DRAIN: no response produced; wait for div_rdy_i, then go to IDLE. req_rdy_o=0.
- Reset mid-operation: the controller clears asynchronously. The divider shares rst and clears on the next clk edge; no response is produced.

Optional Feature:
- Macro DIV_RESULT_CACHE_EN.
- Defined:
  - Keep registers last_a, last_b, last_signed, last_q, last_r and a valid bit.
  - The valid bit is set on every normal completion that reaches RESP, and cleared by rst or by a flush in ISSUE/WAIT/DRAIN.
  - An accepted request matching a, b and signedness with valid=1 bypasses the divider and goes to RESP in 1 cycle, selecting q or r by op. This covers a DIV followed by a REM on the same operands.
- Undefined: no cache registers; every non-special request goes through the divider.

Test Plan:
- DIV a=-7 (0xFFFFFFF9), b=2: div_div1_o=7, div_div2_o=2 -> resp_data_o=0xFFFFFFFD (-3). REM on the same operands -> 0xFFFFFFFF (-1). Tag echoed.
- DIVU a=100, b=0 -> no div_vld_o, resp_vld_o 1 cycle after accept, data 0xFFFFFFFF. REMU -> 100.
- DIV a=0x80000000, b=0xFFFFFFFF -> 1-cycle bypass, data 0x80000000. REM -> 0.
- DIVU a=0xFFFFFFFF, b=1 with resp_rdy_i held low 5 cycles -> data 0xFFFFFFFF, resp_vld_o, data and tag stable throughout, req_rdy_o=0 until the handshake.
- DIVU 1000/3, flush_i pulsed 2 cycles after div_vld_o -> state DRAIN, no resp_vld_o, req_rdy_o returns 1 the cycle after div_rdy_i. The next request DIVU 9/3 returns 3.
- With DIV_RESULT_CACHE_EN: DIV 100/7 -> 14, then REM 100/7 -> 2 with 1-cycle latency and no div_vld_o. After a flush, REM 100/7 uses the divider again.
